// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack controller and the stack memory:
// op codes, FSM state encodings and default geometry.
package stack_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ILL  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_PEEK = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WRITE = 2'b01,
    S_READ  = 2'b10,
    S_RESP  = 2'b11
  } state_e;

  localparam int DEPTH_DEF = 32;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 32;

endpackage

// File: rtl/stack_ctrl.sv
// Stack controller: owns the stack pointer and sequences push/pop/peek
// requests into single-cycle accesses on the external stack memory.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [DW-1:0] req_data,
  input  logic          flush,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW:0]   sp
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_e        state_q;
  state_e        state_d;
  op_e           op_q;
  logic [DW-1:0] data_q;
  logic [AW:0]   sp_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_err_q;

  logic accept;
  logic push_ok;
  logic read_ok;

  assign sp       = sp_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

  // Request qualification: flush wins over a pending request in IDLE.
  always_comb begin
    accept  = (state_q == S_IDLE) && !flush && !reset && req_valid;
    push_ok = (req_op == OP_PUSH) && (sp_q != FULL);
    read_ok = ((req_op == OP_POP) || (req_op == OP_PEEK))
              && (sp_q != '0);
  end

  // Next state and memory/handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = !flush && !reset;
        if (accept) begin
          if (push_ok)      state_d = S_WRITE;
          else if (read_ok) state_d = S_READ;
          else              state_d = S_RESP;
        end
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q[AW-1:0];
        mem_wdata = data_q;
        state_d   = S_RESP;
      end
      S_READ: begin
        mem_addr = AW'(sp_q - 1'b1);
        state_d  = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, stack pointer and response datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ILL;
      data_q     <= '0;
      sp_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (flush) begin
            sp_q <= '0;
          end else if (accept) begin
            op_q   <= op_e'(req_op);
            data_q <= req_data;
            if (!push_ok && !read_ok) begin
              rsp_err_q  <= 1'b1;
              rsp_data_q <= '0;
            end
          end
        end
        S_WRITE: begin
          sp_q       <= sp_q + 1'b1;
          rsp_data_q <= data_q;
          rsp_err_q  <= 1'b0;
        end
        S_READ: begin
          rsp_data_q <= mem_rdata;
          rsp_err_q  <= 1'b0;
          if (op_q == OP_POP) sp_q <= sp_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural stack memory.
// Expected values are hand-computed per vector.
module tb_stack_ctrl;
  import stack_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [5:0]  sp;

  logic [31:0] mem [32];

  int checks = 0;
  int errors = 0;

  stack_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .sp        (sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack memory with combinational read.
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] d, input logic exp_err,
                        input logic [31:0] exp_d, input int exp_lat,
                        input logic [5:0] exp_sp, input int exp_we,
                        input logic [4:0] exp_addr);
    int lat;
    int we_cnt;
    logic [4:0] waddr;
    logic got;
    lat = 0; we_cnt = 0; waddr = '0; got = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_data = d;
    #1 chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      lat++;
      @(negedge clk);
      if (mem_we) begin
        we_cnt++;
        waddr = mem_addr;
      end
      if (rsp_valid) got = 1'b1;
      else @(posedge clk);
    end
    chk({tag, ".rsp_valid"}, 32'(got), 32'd1);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, ".data"}, rsp_data, exp_d);
    chk({tag, ".sp"}, 32'(sp), 32'(exp_sp));
    chk({tag, ".we_cnt"}, 32'(we_cnt), 32'(exp_we));
    if (exp_we > 0) chk({tag, ".waddr"}, 32'(waddr), 32'(exp_addr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    logic seen;
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = '0;
    flush = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.sp", 32'(sp), 32'd0);
    chk("rst.rsp_data", rsp_data, 32'd0);
    reset = 1'b0;
    #1 chk("rst.rel_ready", 32'(req_ready), 32'd1);

    run_op("push1", OP_PUSH, 32'h11111111, 0, 32'h11111111, 2, 6'd1, 1, 5'd0);
    run_op("push2", OP_PUSH, 32'h22222222, 0, 32'h22222222, 2, 6'd2, 1, 5'd1);
    run_op("peek", OP_PEEK, 32'h0, 0, 32'h22222222, 2, 6'd2, 0, 5'd0);
    run_op("pop1", OP_POP, 32'h0, 0, 32'h22222222, 2, 6'd1, 0, 5'd0);
    run_op("pop2", OP_POP, 32'h0, 0, 32'h11111111, 2, 6'd0, 0, 5'd0);
    run_op("pop_empty", OP_POP, 32'h0, 1, 32'h0, 1, 6'd0, 0, 5'd0);
    run_op("peek_empty", OP_PEEK, 32'h0, 1, 32'h0, 1, 6'd0, 0, 5'd0);
    run_op("illegal", OP_ILL, 32'h5, 1, 32'h0, 1, 6'd0, 0, 5'd0);

    for (int i = 0; i < 32; i++)
      run_op($sformatf("fill%0d", i), OP_PUSH, 32'hA000_0000 + 32'(i),
             0, 32'hA000_0000 + 32'(i), 2, 6'(i + 1), 1, 5'(i));
    run_op("overflow", OP_PUSH, 32'hDEAD, 1, 32'h0, 1, 6'd32, 0, 5'd0);
    run_op("peek_full", OP_PEEK, 32'h0, 0, 32'hA000_001F, 2, 6'd32, 0, 5'd0);

    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = OP_PUSH; req_data = 32'h77;
    #1 chk("flush.req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    chk("flush.sp", 32'(sp), 32'd0);
    @(negedge clk);
    chk("flush.no_accept", 32'({rsp_valid, mem_we}), 32'd0);

    run_op("push_h", OP_PUSH, 32'hCAFEF00D, 0, 32'hCAFEF00D, 2, 6'd1, 1, 5'd0);
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_POP; req_data = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold.valid0", 32'(rsp_valid), 32'd1);
    held = rsp_data;
    chk("hold.data0", held, 32'hCAFEF00D);
    req_valid = 1'b1; req_op = OP_PUSH; req_data = 32'h99;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== held || req_ready) seen = 1'b1;
    end
    chk("hold.stable", 32'(seen), 32'd0);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    #1 chk("hold.sp", 32'(sp), 32'd0);
    @(negedge clk);
    chk("hold.no_accept", 32'({rsp_valid, mem_we}), 32'd0);

    run_op("push_r", OP_PUSH, 32'h0000AAAA, 0, 32'h0000AAAA, 2, 6'd1, 1, 5'd0);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_PUSH; req_data = 32'h0000BBBB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstw.we_before", 32'({mem_we, 3'b0, mem_addr}), 32'h101);
    #2 reset = 1'b1;
    #1;
    chk("rstw.mem_we", 32'(mem_we), 32'd0);
    chk("rstw.addr_wdata", mem_wdata | 32'(mem_addr), 32'd0);
    chk("rstw.req_ready", 32'(req_ready), 32'd0);
    chk("rstw.rsp", 32'({rsp_valid, rsp_err}) | rsp_data, 32'd0);
    chk("rstw.sp", 32'(sp), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rstw.rel_ready", 32'(req_ready), 32'd1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || mem_we) seen = 1'b1;
    end
    chk("rstw.no_rsp", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
